// File: rtl/dsp_stq_alloc_module_pkg.sv
// Shared dispatch definitions for the store-queue ID allocator: default
// sizing, grant-mode encoding and a counter-width helper.
package dsp_stq_alloc_module_pkg;

  localparam int DEF_DSP_W = 4;
  localparam int DEF_CMT_W = 4;
  localparam int DEF_DRN_W = 1;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_ID_W  = $clog2(DEF_DEPTH);
  localparam int DEF_PTR_W = DEF_ID_W + 1;

  typedef enum logic {
    GRANT_ALL    = 1'b0,
    GRANT_PREFIX = 1'b1
  } grant_mode_e;

  // Bits needed to hold a population count of a w-bit vector.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/dsp_stq_alloc_module_if.sv
// Dispatch-side bundle of the store-queue allocator: requests, flushes,
// commit/drain strobes in; grants, IDs, occupancy and pointers out.
interface dsp_stq_alloc_module_if
  import dsp_stq_alloc_module_pkg::*;
#(
  parameter int DSP_W = DEF_DSP_W,
  parameter int CMT_W = DEF_CMT_W,
  parameter int DRN_W = DEF_DRN_W,
  parameter int ID_W  = DEF_ID_W
);

  logic [DSP_W-1:0]      i_req_vld;
  logic                  i_stall;
  logic                  i_mis_flush;
  logic [ID_W:0]         i_mis_ptr;
  logic                  i_trap_flush;
  logic [CMT_W-1:0]      i_cmt_vld;
  logic [DRN_W-1:0]      i_drn_vld;
  logic [DSP_W-1:0]      o_grant;
  logic [DSP_W*ID_W-1:0] o_alloc_id;
  logic                  o_full;
  logic                  o_empty;
  logic [ID_W:0]         o_free_cnt;
  logic [ID_W:0]         o_alloc_ptr;
  logic [ID_W:0]         o_cmt_ptr;
  logic [ID_W:0]         o_drn_ptr;
  logic                  o_err;

  modport master (
    output i_req_vld, i_stall, i_mis_flush, i_mis_ptr, i_trap_flush,
           i_cmt_vld, i_drn_vld,
    input  o_grant, o_alloc_id, o_full, o_empty, o_free_cnt,
           o_alloc_ptr, o_cmt_ptr, o_drn_ptr, o_err
  );

  modport slave (
    input  i_req_vld, i_stall, i_mis_flush, i_mis_ptr, i_trap_flush,
           i_cmt_vld, i_drn_vld,
    output o_grant, o_alloc_id, o_full, o_empty, o_free_cnt,
           o_alloc_ptr, o_cmt_ptr, o_drn_ptr, o_err
  );

endinterface

// File: rtl/dsp_prefix_cnt_module.sv
// Population count of a lane vector plus, per lane, the exclusive count of
// set lanes below it.
module dsp_prefix_cnt_module
  import dsp_stq_alloc_module_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = cnt_w(W)
) (
  input  logic [W-1:0]         vec,
  output logic [CW-1:0]        cnt,
  output logic [W-1:0][CW-1:0] pre
);

  always_comb begin
    logic [CW-1:0] acc;
    // NOTE: blocking assignments here build a ripple chain evaluated in
    // order within one pass; non-blocking would read stale values.
    acc = '0;
    for (int k = 0; k < W; k++) begin
      pre[k] = acc;
      acc    = acc + CW'(vec[k]);
    end
    cnt = acc;
  end

endmodule

// File: rtl/dsp_stq_alloc_module.sv
// Store-ID allocator: circular alloc/commit/drain pointers over a DEPTH-entry
// pool with per-cycle multi-lane grant, flush rollback and sticky error.
module dsp_stq_alloc_module
  import dsp_stq_alloc_module_pkg::*;
#(
  parameter int DSP_W   = DEF_DSP_W,
  parameter int CMT_W   = DEF_CMT_W,
  parameter int DRN_W   = DEF_DRN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PARTIAL = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  dsp_stq_alloc_module_if.slave bus
);

  localparam int ID_W = $clog2(DEPTH);
  localparam int PW   = ID_W + 1;
  localparam int RCW  = cnt_w(DSP_W);
  localparam int CCW  = cnt_w(CMT_W);
  localparam int DCW  = cnt_w(DRN_W);
  localparam grant_mode_e MODE = (PARTIAL != 0) ? GRANT_PREFIX : GRANT_ALL;

  logic [PW-1:0] alloc_q, cmt_q, drn_q;
  logic          err_q;

  logic [RCW-1:0]              req_cnt;
  logic [DSP_W-1:0][RCW-1:0]   req_pre;
  logic [CCW-1:0]              cmt_cnt;
  logic [CMT_W-1:0][CCW-1:0]   cmt_pre;
  logic [DCW-1:0]              drn_cnt;
  logic [DRN_W-1:0][DCW-1:0]   drn_pre;

  dsp_prefix_cnt_module #(.W(DSP_W), .CW(RCW)) u_req_cnt (
    .vec (bus.i_req_vld), .cnt (req_cnt), .pre (req_pre)
  );
  dsp_prefix_cnt_module #(.W(CMT_W), .CW(CCW)) u_cmt_cnt (
    .vec (bus.i_cmt_vld), .cnt (cmt_cnt), .pre (cmt_pre)
  );
  dsp_prefix_cnt_module #(.W(DRN_W), .CW(DCW)) u_drn_cnt (
    .vec (bus.i_drn_vld), .cnt (drn_cnt), .pre (drn_pre)
  );

  logic [PW-1:0]    free, grant_cnt, cmt_nx, drn_nx, alloc_nx;
  logic [DSP_W-1:0] grant;
  logic             alloc_en, cmt_err, drn_err, mis_err;

  // Modular differences; the wrap bit keeps a full pool distinct from empty.
  assign free     = PW'(DEPTH) - (alloc_q - drn_q);
  assign alloc_en = !bus.i_stall && !bus.i_mis_flush && !bus.i_trap_flush;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_cnt = '0;
    if (alloc_en) begin
      if (MODE == GRANT_ALL) begin
        if (PW'(req_cnt) <= free) grant = bus.i_req_vld;
      end else begin
        for (int k = 0; k < DSP_W; k++)
          grant[k] = bus.i_req_vld[k] && (PW'(req_pre[k]) < free);
      end
    end
    for (int k = 0; k < DSP_W; k++)
      grant_cnt = grant_cnt + PW'(grant[k]);
  end

  // Granted lanes always form a prefix of the requesters, so the request
  // prefix count equals the granted-lanes-below count for every granted lane.
  always_comb begin
    bus.o_alloc_id = '0;
    for (int k = 0; k < DSP_W; k++)
      bus.o_alloc_id[k*ID_W +: ID_W] = alloc_q[ID_W-1:0] + ID_W'(req_pre[k]);
  end

  // A commit (drain) lane is illegal when its slot lies at or beyond alloc (cmt).
  always_comb begin
    cmt_err = 1'b0;
    drn_err = 1'b0;
    for (int k = 0; k < CMT_W; k++)
      if (bus.i_cmt_vld[k] && (PW'(cmt_pre[k]) >= alloc_q - cmt_q)) cmt_err = 1'b1;
    for (int k = 0; k < DRN_W; k++)
      if (bus.i_drn_vld[k] && (PW'(drn_pre[k]) >= cmt_q - drn_q)) drn_err = 1'b1;
  end

  assign cmt_nx  = cmt_err ? cmt_q : cmt_q + PW'(cmt_cnt);
  assign drn_nx  = drn_err ? drn_q : drn_q + PW'(drn_cnt);
  assign mis_err = bus.i_mis_flush && !bus.i_trap_flush &&
                   ((bus.i_mis_ptr - cmt_nx) > (alloc_q - cmt_nx));

  always_comb begin
    alloc_nx = alloc_q + grant_cnt;
    if (bus.i_trap_flush)     alloc_nx = cmt_nx;
    else if (bus.i_mis_flush) alloc_nx = mis_err ? alloc_q : bus.i_mis_ptr;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      alloc_q <= '0;
      cmt_q   <= '0;
      drn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_nx;
      cmt_q   <= cmt_nx;
      drn_q   <= drn_nx;
      err_q   <= err_q | cmt_err | drn_err | mis_err;
    end
  end

  assign bus.o_grant     = grant;
  assign bus.o_full      = (|bus.i_req_vld) && !bus.i_stall && (grant != bus.i_req_vld);
  assign bus.o_empty     = (alloc_q == drn_q);
  assign bus.o_free_cnt  = free;
  assign bus.o_alloc_ptr = alloc_q;
  assign bus.o_cmt_ptr   = cmt_q;
  assign bus.o_drn_ptr   = drn_q;
  assign bus.o_err       = err_q;

endmodule
